// File: rtl/mem_io_responder_pkg.sv
// Shared widths, I/O map and address decode helper for the CPU byte-bus responder.
package mem_io_responder_pkg;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DWORD_W = 32;
    localparam int unsigned DEC_W   = 18;

    localparam logic [DEC_W-1:0] IO_PORT_ADDR = 18'h30000;
    localparam logic [DEC_W-1:0] IO_CLK_ADDR  = 18'h30004;
    localparam logic [1:0]       IO_SEL_BITS  = 2'b11;

    typedef enum logic [1:0] {TGT_RAM, TGT_PORT, TGT_CLK, TGT_NONE} target_e;

    typedef struct packed {
        logic              wr;
        logic [DEC_W-1:0]  addr;
        logic [BYTE_W-1:0] data;
    } bus_req_t;

    // Classify a decoded address; the clock window covers the four counter byte lanes.
    function automatic target_e decode_target(input logic [DEC_W-1:0] addr);
        if (addr[DEC_W-1 -: 2] != IO_SEL_BITS) return TGT_RAM;
        if (addr == IO_PORT_ADDR) return TGT_PORT;
        if (addr[DEC_W-1:2] == IO_CLK_ADDR[DEC_W-1:2]) return TGT_CLK;
        return TGT_NONE;
    endfunction
endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte-bus plus UART tx/rx handshake signals seen by the memory/I/O responder.
interface mem_io_responder_if;
    import mem_io_responder_pkg::*;

    logic [DWORD_W-1:0] mem_a;
    logic               mem_wr;
    logic [BYTE_W-1:0]  mem_dout;
    logic [BYTE_W-1:0]  mem_din;
    logic               io_buffer_full;
    logic [BYTE_W-1:0]  tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [BYTE_W-1:0]  rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               prog_stop;

    modport master (
        output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
        input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, prog_stop
    );

    modport slave (
        input  mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
        output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, prog_stop
    );
endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is taken only when a pop frees a slot.
module mem_io_responder_byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [BYTE_W-1:0]       wdata,
    output logic [BYTE_W-1:0]       rdata_c,
    output logic                    full_c,
    output logic                    empty_c,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty_c = (count == '0);
    assign full_c  = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);
    assign rdata_c = empty_c ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/mem_io_responder.sv
// Target side of the CPU byte bus: 128 KB RAM plus UART, cycle counter and stop flag I/O window.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W  = 17,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    mem_io_responder_if.slave   bus
);
    localparam int unsigned CNT_W     = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_W;

    bus_req_t              req;
    target_e               tgt;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [BYTE_W-1:0]     ram [RAM_BYTES];

    logic [BYTE_W-1:0]  rd_data_c;
    logic               push_c;
    logic [BYTE_W-1:0]  push_data_c;
    logic               rx_take_c;
    logic               stop_hit_c;
    logic               snap_load_c;
    logic [DWORD_W-1:0] clk_src_c;

    logic [BYTE_W-1:0]  mem_din_q;
    logic [DWORD_W-1:0] cycle_cnt;
    logic [DWORD_W-1:0] snapshot;
    logic               prog_stop_q;
    logic               full_q;

    logic [BYTE_W-1:0]  fifo_rdata;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               unused_fifo_full;
    logic               unused_addr_hi;

    assign req            = '{wr: bus.mem_wr, addr: bus.mem_a[DEC_W-1:0], data: bus.mem_dout};
    assign tgt            = decode_target(req.addr);
    assign ram_addr       = req.addr[RAM_ADDR_W-1:0];
    assign unused_addr_hi = ^bus.mem_a[DWORD_W-1:DEC_W];

    // Per-access side effects and the byte that will appear on mem_din next cycle.
    always_comb begin
        rd_data_c   = '0;
        push_c      = 1'b0;
        push_data_c = req.data;
        rx_take_c   = 1'b0;
        stop_hit_c  = 1'b0;
        snap_load_c = 1'b0;
        clk_src_c   = snapshot;
        unique case (tgt)
            TGT_RAM: begin
                if (!req.wr) rd_data_c = ram[ram_addr];
            end
            TGT_PORT: begin
                if (req.wr) begin
                    push_c = (req.data != '0);
                end else if (bus.rx_valid) begin
                    rd_data_c = bus.rx_data;
                    rx_take_c = 1'b1;
                end
            end
            TGT_CLK: begin
                if (req.wr) begin
                    if (req.addr == IO_CLK_ADDR) begin
                        stop_hit_c  = 1'b1;
                        push_c      = 1'b1;
                        push_data_c = '0;
                    end
                end else begin
                    // Lane 0 samples the live counter so the dword read back is coherent.
                    if (req.addr[1:0] == 2'b00) begin
                        snap_load_c = 1'b1;
                        clk_src_c   = cycle_cnt;
                    end
                    rd_data_c = clk_src_c[{req.addr[1:0], 3'b000} +: BYTE_W];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_din_q   <= '0;
            cycle_cnt   <= '0;
            snapshot    <= '0;
            prog_stop_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            mem_din_q <= rd_data_c;
            cycle_cnt <= cycle_cnt + DWORD_W'(1);
            full_q    <= (fifo_count >= CNT_W'(TX_DEPTH - FULL_MARGIN));
            if (snap_load_c) snapshot    <= cycle_cnt;
            if (stop_hit_c)  prog_stop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (tgt == TGT_RAM && req.wr) ram[ram_addr] <= req.data;
    end

    mem_io_responder_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .push    (push_c),
        .pop     (bus.tx_ready),
        .wdata   (push_data_c),
        .rdata_c (fifo_rdata),
        .full_c  (unused_fifo_full),
        .empty_c (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.mem_din        = mem_din_q;
    assign bus.io_buffer_full = full_q;
    assign bus.tx_data        = fifo_rdata;
    assign bus.tx_valid       = !fifo_empty;
    assign bus.rx_ready       = rst_n_in && rx_take_c;
    assign bus.prog_stop      = prog_stop_q;
endmodule
